// File: rtl/horner_decoder_pkg.sv
// horner_decoder_pkg: shared state encoding and default geometry for the accumulator link
package horner_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W         = 100;
    localparam int DEF_FRAME_LEN = 99;
    localparam int DEF_CNT_W     = 7;

endpackage

// File: rtl/horner_decoder_cnt.sv
// horner_decoder_cnt: frame word counter with synchronous clear on frame start/end
module horner_decoder_cnt #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // count accepted words, clearing when a frame is armed or completes
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/horner_decoder.sv
// horner_decoder: recovers samples x_k = acc_k - 2*acc_{k-1} from a shift-accumulated stream
module horner_decoder
    import horner_decoder_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
);

    state_t           state;
    logic [W-1:0]     acc_prev;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             accept;
    logic             last_word;

    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign xfer      = in_valid && in_ready;
    assign accept    = out_valid && out_ready;
    assign last_word = cnt == CNT_W'(FRAME_LEN - 1);
    assign busy      = state != IDLE;

    horner_decoder_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr ((state == IDLE && start) || (xfer && last_word)),
        .inc (xfer),
        .cnt (cnt)
    );

    // frame sequencing and previous-accumulator tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc_prev <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    state    <= RUN;
                    acc_prev <= '0;
                end
                RUN: if (xfer) begin
                    acc_prev <= in_data;
                    if (last_word) state <= DONE;
                end
                DONE: if (accept && out_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // single output register: load on transfer, drain on accept, hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data - (acc_prev << 1);
            out_last  <= last_word;
        end else if (accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_horner_decoder.sv
// tb_horner_decoder: scoreboard bench for the Horner decoder, small (W=8) and full-size instances
module tb_horner_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         s_start, s_in_valid, s_in_ready, s_out_valid, s_out_last, s_out_ready, s_busy;
    logic [7:0]   s_in_data, s_out_data;
    logic         b_start, b_in_valid, b_in_ready, b_out_valid, b_out_last, b_out_ready, b_busy;
    logic [99:0]  b_in_data, b_out_data;

    int compared = 0;
    int mismatched = 0;
    logic [8:0]   sq[$];
    logic [100:0] bq[$];

    horner_decoder #(.W(8), .FRAME_LEN(3), .CNT_W(2)) u_s (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_last(s_out_last), .out_ready(s_out_ready), .busy(s_busy)
    );

    horner_decoder u_b (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_last(b_out_last), .out_ready(b_out_ready), .busy(b_busy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // small-instance output monitor
    always @(negedge clk) begin : s_mon
        logic [8:0] e;
        if (s_out_valid && s_out_ready) begin
            if (sq.size() == 0) chk("s_out_unexpected", {s_out_last, s_out_data}, 'x);
            else begin
                e = sq.pop_front();
                chk("s_out", {s_out_last, s_out_data}, e);
            end
        end
    end

    // full-size-instance output monitor
    always @(negedge clk) begin : b_mon
        logic [100:0] e;
        if (b_out_valid && b_out_ready) begin
            if (bq.size() == 0) chk("b_out_unexpected", {b_out_last, b_out_data}, 'x);
            else begin
                e = bq.pop_front();
                chk("b_out", {b_out_last, b_out_data}, e);
            end
        end
    end

    task automatic s_send(input logic [7:0] d, input logic [7:0] x, input logic l);
        int n = 0;
        s_in_valid = 1'b1;
        s_in_data  = d;
        @(negedge clk);
        while (!s_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (s_in_ready) begin
            sq.push_back({l, x});
            tick;
            s_in_valid = 1'b0;
            chk("s_lat_valid", s_out_valid, 1);
            chk("s_lat_data", {s_out_last, s_out_data}, {l, x});
        end else begin
            chk("s_send_timeout", s_in_ready, 1);
            tick;
            s_in_valid = 1'b0;
        end
    endtask

    task automatic b_send(input logic [99:0] d, input logic [99:0] x, input logic l);
        int n = 0;
        b_in_valid = 1'b1;
        b_in_data  = d;
        @(negedge clk);
        while (!b_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (b_in_ready) begin
            bq.push_back({l, x});
            tick;
            b_in_valid = 1'b0;
        end else begin
            chk("b_send_timeout", b_in_ready, 1);
            tick;
            b_in_valid = 1'b0;
        end
    endtask

    task automatic s_pulse_start;
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
    endtask

    task automatic wait_idle(input bit big);
        int n = 0;
        while ((big ? b_busy : s_busy) && n < 300) begin
            tick;
            n++;
        end
        chk(big ? "b_idle" : "s_idle", big ? b_busy : s_busy, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [127:0] r;
        logic [99:0]  acc, x;
        rst = 1'b1;
        s_start = 0; s_in_valid = 0; s_in_data = '0; s_out_ready = 1;
        b_start = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 1;
        repeat (3) tick;
        @(negedge clk);
        chk("rst_in_ready", s_in_ready, 0);
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_out_data", s_out_data, 0);
        chk("rst_out_last", s_out_last, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_b_busy", b_busy, 0);
        tick;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        s_start = 1'b1;
        tick;
        rst = 1'b0;
        s_start = 1'b0;
        @(negedge clk);
        chk("start_with_rst_busy", s_busy, 0);
        tick;
        s_pulse_start;
        s_send(8'h01, 8'h01, 0);
        s_send(8'h02, 8'h00, 0);
        s_send(8'h07, 8'h03, 1);
        wait_idle(0);
        s_pulse_start;
        s_send(8'h80, 8'h80, 0);
        s_send(8'h05, 8'h05, 0);
        s_send(8'h0A, 8'h00, 1);
        wait_idle(0);
        s_pulse_start;
        s_send(8'h03, 8'h03, 0);
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 8'h09;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", s_in_ready, 0);
            chk("bp_out_valid", s_out_valid, 1);
            chk("bp_out_data", s_out_data, 8'h03);
            tick;
        end
        s_out_ready = 1'b1;
        s_send(8'h09, 8'h03, 0);
        s_send(8'h10, 8'hFE, 1);
        wait_idle(0);
        s_pulse_start;
        s_send(8'h10, 8'h10, 0);
        s_send(8'h25, 8'h05, 0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", s_in_ready, 0);
        chk("midrst_out_valid", s_out_valid, 0);
        chk("midrst_out_data", s_out_data, 0);
        chk("midrst_out_last", s_out_last, 0);
        chk("midrst_busy", s_busy, 0);
        tick;
        s_pulse_start;
        s_send(8'h03, 8'h03, 0);
        s_send(8'h07, 8'h01, 0);
        s_send(8'h0E, 8'h00, 1);
        wait_idle(0);
        s_in_valid = 1'b1;
        s_in_data  = 8'h55;
        repeat (5) begin
            @(negedge clk);
            chk("idle_in_ready", s_in_ready, 0);
            chk("idle_out_valid", s_out_valid, 0);
            tick;
        end
        s_in_valid = 1'b0;
        s_pulse_start;
        s_send(8'h01, 8'h01, 0);
        s_pulse_start;
        s_send(8'h01, 8'hFF, 0);
        s_send(8'h01, 8'hFF, 1);
        wait_idle(0);
        b_start = 1'b1;
        tick;
        b_start = 1'b0;
        acc = '0;
        for (int i = 0; i < 99; i++) begin
            r   = {$urandom, $urandom, $urandom, $urandom};
            x   = r[99:0];
            acc = (acc << 1) + x;
            b_send(acc, x, i == 98);
        end
        wait_idle(1);
        repeat (3) tick;
        chk("s_queue_empty", sq.size(), 0);
        chk("b_queue_empty", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
